// File: rtl/rf_read_arbiter_if.sv
// Requester-side bundle for rf_read_arbiter: core and network request/response
// channels plus the shared response data. Optional build macro: RF_ARB_ZERO_X0_EN.
interface rf_read_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              core_req_valid;
    logic              core_req_ready;
    logic [ADDR_W-1:0] core_rs1;
    logic [ADDR_W-1:0] core_rs2;
    logic              core_rsp_valid;
    logic              core_rsp_ready;

    logic              net_req_valid;
    logic              net_req_ready;
    logic [ADDR_W-1:0] net_rs1;
    logic [ADDR_W-1:0] net_rs2;
    logic              net_rsp_valid;
    logic              net_rsp_ready;

    logic [DATA_W-1:0] rsp_data1;
    logic [DATA_W-1:0] rsp_data2;

    modport master (
        output core_req_valid, core_rs1, core_rs2, core_rsp_ready,
        output net_req_valid, net_rs1, net_rs2, net_rsp_ready,
        input  core_req_ready, core_rsp_valid,
        input  net_req_ready, net_rsp_valid,
        input  rsp_data1, rsp_data2
    );

    modport slave (
        input  core_req_valid, core_rs1, core_rs2, core_rsp_ready,
        input  net_req_valid, net_rs1, net_rs2, net_rsp_ready,
        output core_req_ready, core_rsp_valid,
        output net_req_ready, net_rsp_valid,
        output rsp_data1, rsp_data2
    );
endinterface

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter/sequencer sharing the register-file dual read mux between
// core and network. Define RF_ARB_ZERO_X0_EN to return zero for register index 0.
module rf_read_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    rf_read_arbiter_if.slave  bus,
    output logic [ADDR_W-1:0] selrs1,
    output logic [ADDR_W-1:0] selrs2,
    output logic              reg_select,
    input  logic [DATA_W-1:0] mux_data1,
    input  logic [DATA_W-1:0] mux_data2,
    output logic              busy
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEL  = 2'd1;
    localparam logic [1:0] ST_CAP  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]        state;
    logic              last_grant;   // 0 core, 1 net
    logic              grant_core;
    logic              grant_net;
    logic              accept;
    logic              owner_ready;
    logic [DATA_W-1:0] cap1;
    logic [DATA_W-1:0] cap2;
    logic [DATA_W-1:0] rsp_q1;
    logic [DATA_W-1:0] rsp_q2;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant_core  = bus.core_req_valid & (~bus.net_req_valid | last_grant);
        grant_net   = bus.net_req_valid & (~bus.core_req_valid | ~last_grant);
        accept      = (state == ST_IDLE) & (bus.core_req_valid | bus.net_req_valid);
        owner_ready = reg_select ? bus.net_rsp_ready : bus.core_rsp_ready;
    end

    always_comb begin
`ifdef RF_ARB_ZERO_X0_EN
        cap1 = (selrs1 == '0) ? '0 : mux_data1;
        cap2 = (selrs2 == '0) ? '0 : mux_data2;
`else
        cap1 = mux_data1;
        cap2 = mux_data2;
`endif
    end

    always_comb begin
        bus.core_req_ready = (state == ST_IDLE) & grant_core;
        bus.net_req_ready  = (state == ST_IDLE) & grant_net;
        bus.core_rsp_valid = (state == ST_RESP) & ~reg_select;
        bus.net_rsp_valid  = (state == ST_RESP) & reg_select;
        bus.rsp_data1      = rsp_q1;
        bus.rsp_data2      = rsp_q2;
        busy               = (state != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            reg_select <= 1'b0;
            selrs1     <= '0;
            selrs2     <= '0;
            rsp_q1     <= '0;
            rsp_q2     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_SEL;
                        reg_select <= grant_net;
                        last_grant <= grant_net;
                        selrs1     <= grant_net ? bus.net_rs1 : bus.core_rs1;
                        selrs2     <= grant_net ? bus.net_rs2 : bus.core_rs2;
                    end
                end
                ST_SEL: state <= ST_CAP;
                ST_CAP: begin
                    rsp_q1 <= cap1;
                    rsp_q2 <= cap2;
                    state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (owner_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
